// File: rtl/pwm_seno_multicanal.sv
`default_nettype none
// ============================================================================
// Module   : pwm_seno_multicanal
// Brief    : Multi-channel sine-modulated PWM; one shared carrier and sine-step
//            sequencer, per-channel phase offset into a shared sine table.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_seno_multicanal #(
  parameter  int R       = 6,
  parameter  int CANALES = 3,
  parameter  int PASOS   = 36,
  localparam int IDXW    = $clog2(PASOS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    modo,
  input  logic [R-1:0]            duty_fijo,
  input  logic [15:0]             pasos_por_muestra,
  input  logic [CANALES*IDXW-1:0] fase,
  output logic [CANALES-1:0]      pwm_out,
  output logic                    fin_periodo,
  output logic [IDXW-1:0]         indice
);

  localparam real             c_pi       = 3.14159265358979323846;
  localparam logic [R-1:0]    c_qmax     = {R{1'b1}};
  localparam logic [IDXW-1:0] c_last_idx = IDXW'(PASOS - 1);
  localparam logic [IDXW:0]   c_pasos    = (IDXW+1)'(PASOS);

  function automatic logic [R-1:0] lut_val(input int k);
    real v;
    v = ((2.0 ** R) - 1.0) * (1.0 + $sin(2.0 * c_pi * k / PASOS)) / 2.0 + 0.5;
    return R'($rtoi($floor(v)));
  endfunction

  logic [R-1:0]    r_q;
  logic [15:0]     r_n;
  logic [IDXW-1:0] r_indice;
  logic [R-1:0]    r_ciclo_act [CANALES];
  logic [CANALES-1:0] r_pwm;
  logic            r_fin;

  logic [R-1:0]    w_lut       [PASOS];
  logic [IDXW-1:0] w_idx       [CANALES];
  logic [R-1:0]    w_ciclo_sig [CANALES];
  logic            w_wrap;
  logic [15:0]     w_lim;

  for (genvar k = 0; k < PASOS; k++) begin : g_lut
    assign w_lut[k] = lut_val(k);
  end

  for (genvar c = 0; c < CANALES; c++) begin : g_canal
    logic [IDXW-1:0] w_fase_c;
    logic [IDXW:0]   w_suma;

    // Out-of-range phase offsets fall back to zero instead of indexing past the table.
    assign w_fase_c       = ({1'b0, fase[c*IDXW +: IDXW]} >= c_pasos) ? '0 : fase[c*IDXW +: IDXW];
    assign w_suma         = {1'b0, r_indice} + {1'b0, w_fase_c};
    assign w_idx[c]       = (w_suma >= c_pasos) ? IDXW'(w_suma - c_pasos) : w_suma[IDXW-1:0];
    assign w_ciclo_sig[c] = modo ? duty_fijo : w_lut[w_idx[c]];
  end

  assign w_wrap = en & (r_q == c_qmax);
  assign w_lim  = (pasos_por_muestra == 16'd0) ? 16'd0 : pasos_por_muestra - 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= '0;
      r_n      <= '0;
      r_indice <= '0;
      r_pwm    <= '0;
      r_fin    <= 1'b0;
      for (int c = 0; c < CANALES; c++) begin
        r_ciclo_act[c] <= '0;
      end
    end else begin
      r_fin <= w_wrap;
      if (en) begin
        r_q <= r_q + R'(1);
      end
      // Duties are latched only at the carrier wrap so a period is never cut short.
      if (w_wrap) begin
        for (int c = 0; c < CANALES; c++) begin
          r_ciclo_act[c] <= w_ciclo_sig[c];
        end
        if (r_n == w_lim) begin
          r_n      <= '0;
          r_indice <= (r_indice == c_last_idx) ? '0 : r_indice + IDXW'(1);
        end else begin
          r_n <= r_n + 16'd1;
        end
      end
      for (int c = 0; c < CANALES; c++) begin
        r_pwm[c] <= en & (r_q < r_ciclo_act[c]);
      end
    end
  end

  assign pwm_out     = r_pwm;
  assign fin_periodo = r_fin;
  assign indice      = r_indice;

endmodule
`default_nettype wire

// File: tb/tb_pwm_seno_multicanal.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_seno_multicanal
// Brief    : Scoreboard bench; per-period duty/indice expectations are queued
//            at stimulus time and checked by a monitor on each fin_periodo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_seno_multicanal;

  localparam int R       = 6;
  localparam int CANALES = 3;
  localparam int PASOS   = 36;
  localparam int IDXW    = 6;
  localparam int PER     = 64;
  localparam int NPER    = 120;
  localparam real PI     = 3.14159265358979323846;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    en = 1'b0;
  logic                    modo = 1'b0;
  logic [R-1:0]            duty_fijo = '0;
  logic [15:0]             pps = 16'd1;
  logic [CANALES*IDXW-1:0] fase = '0;
  logic [CANALES-1:0]      pwm_out;
  logic                    fin_periodo;
  logic [IDXW-1:0]         indice;

  always #5 clk = ~clk;

  pwm_seno_multicanal #(.R(R), .CANALES(CANALES), .PASOS(PASOS)) dut (
    .clk               (clk),
    .rst               (rst),
    .en                (en),
    .modo              (modo),
    .duty_fijo         (duty_fijo),
    .pasos_por_muestra (pps),
    .fase              (fase),
    .pwm_out           (pwm_out),
    .fin_periodo       (fin_periodo),
    .indice            (indice)
  );

  typedef struct packed {
    logic [CANALES-1:0][7:0] d;
    logic [7:0]              idx;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   lut [PASOS];
  int   gap_len [1024];
  int   m_idx = 0;
  int   m_n = 0;
  bit   abort_run = 1'b0;

  task automatic chk(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int fase_of(input logic [CANALES*IDXW-1:0] f, input int c);
    int v;
    v = int'(f[c*IDXW +: IDXW]);
    return (v >= PASOS) ? 0 : v;
  endfunction

  // Model of one carrier wrap: duties come from the pre-step index, then the step advances.
  task automatic push_expected();
    exp_t e;
    int   lim;
    for (int c = 0; c < CANALES; c++) begin
      e.d[c] = modo ? 8'(duty_fijo) : 8'(lut[(m_idx + fase_of(fase, c)) % PASOS]);
    end
    lim = (pps == 16'd0) ? 1 : int'(pps);
    if (m_n == lim - 1) begin
      m_n   = 0;
      m_idx = (m_idx + 1) % PASOS;
    end else begin
      m_n++;
    end
    e.idx = 8'(m_idx);
    sb_q.push_back(e);
  endtask

  // Only pick step rates whose limit the running sub-step count has not passed.
  task automatic set_pps(input int v);
    int lim;
    lim = (v == 0) ? 1 : v;
    if (lim - 1 >= m_n) pps = 16'(v);
  endtask

  task automatic rand_settings(input bit constrain_pps);
    int v;
    modo = ($urandom_range(0, 3) == 0);
    case ($urandom_range(0, 3))
      0:       duty_fijo = '0;
      1:       duty_fijo = '1;
      default: duty_fijo = R'($urandom_range(0, 63));
    endcase
    for (int c = 0; c < CANALES; c++) begin
      fase[c*IDXW +: IDXW] = ($urandom_range(0, 9) == 0) ? IDXW'($urandom_range(36, 63))
                                                         : IDXW'($urandom_range(0, 35));
    end
    v = $urandom_range(0, 3);
    if (constrain_pps) set_pps(v);
    else pps = 16'(v);
  endtask

  task automatic final_settings(input int p);
    if (p < 3) begin
      modo = 1'b0;
      fase = {6'd24, 6'd12, 6'd0};
      set_pps(1);
    end else if (p < 6) begin
      modo      = 1'b1;
      duty_fijo = 6'd16;
      set_pps(1);
    end else if (p < 15) begin
      modo = 1'b0;
      fase = '0;
      set_pps(3);
    end else if (p < 21) begin
      modo = 1'b0;
      set_pps(0);
    end else begin
      rand_settings(1'b1);
    end
  endtask

  task automatic start_after_reset();
    exp_t z;
    z = '0;
    sb_q.delete();
    m_idx = 0;
    m_n   = 0;
    sb_q.push_back(z);
    rst = 1'b0;
    en  = 1'b1;
  endtask

  task automatic do_reset();
    modo = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_fin_periodo", int'(fin_periodo), 0);
    chk("rst_indice", int'(indice), 0);
    start_after_reset();
  endtask

  task automatic run_period(input int p, input int per);
    int  g;
    bit  got;
    gap_len[p] = 0;
    rand_settings(1'b0);
    repeat ($urandom_range(1, 20)) @(negedge clk);
    final_settings(per);
    push_expected();
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      en = 1'b0;
      g  = $urandom_range(1, 12);
      repeat (g) @(negedge clk);
      en = 1'b1;
      gap_len[p] = g;
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (fin_periodo) got = 1'b1;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL fin_timeout: got no fin_periodo within 200 clocks, expected one per %0d", PER);
      abort_run = 1'b1;
    end
  endtask

  initial begin
    int p;
    for (int k = 0; k < PASOS; k++) begin
      lut[k] = int'($floor(63.0 * (1.0 + $sin(2.0 * PI * k / 36.0)) / 2.0 + 0.5));
    end
    for (int i = 0; i < 1024; i++) gap_len[i] = 0;

    en  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_fin_periodo", int'(fin_periodo), 0);
    chk("rst_indice", int'(indice), 0);
    start_after_reset();

    p = 0;
    for (int per = 0; per < NPER && !abort_run; per++) begin
      if (per == 90) begin
        do_reset();
        p = 0;
      end
      run_period(p, per);
      p++;
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: integrates high clocks per channel between fin_periodo pulses.
  initial begin
    int   cnt [CANALES];
    int   len;
    int   start_idx;
    int   w;
    bit   first;
    exp_t e;
    len = 0; start_idx = 0; w = 0; first = 1'b1;
    for (int c = 0; c < CANALES; c++) cnt[c] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        for (int c = 0; c < CANALES; c++) cnt[c] = 0;
        len       = 0;
        first     = 1'b1;
        start_idx = int'(indice);
        w         = 0;
      end else begin
        for (int c = 0; c < CANALES; c++) cnt[c] += int'(pwm_out[c]);
        len++;
        if (fin_periodo) begin
          if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty: got fin_periodo, expected no pulse (t=%0t)", $time);
          end else begin
            e = sb_q.pop_front();
            for (int c = 0; c < CANALES; c++) begin
              chk($sformatf("duty_ch%0d_win%0d", c, w), cnt[c], int'(e.d[c]));
            end
            chk($sformatf("indice_win%0d", w), start_idx, int'(e.idx));
            if (!first) chk($sformatf("period_len_win%0d", w), len, PER + gap_len[w]);
          end
          for (int c = 0; c < CANALES; c++) cnt[c] = 0;
          len       = 0;
          start_idx = int'(indice);
          first     = 1'b0;
          w++;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/pwm_seno_multicanal.md
Name: pwm_seno_multicanal

Overview:
Multi-channel sine-modulated PWM generator, the parametrised successor of the single-channel sine PWM.
- All channels share one R-bit carrier counter and one sine-step sequencer.
- Each channel adds its own phase offset into the sine table, so three-phase and other phased outputs come from one block.
- Adds synchronous reset, enable, a fixed-duty mode, a runtime step rate and duty updates that only take effect at period boundaries (glitch-free).

Parameters:
R, 6, carrier counter width; PWM period = 2^R clocks; duty resolution R bits
CANALES, 3, number of PWM output channels
PASOS, 36, sine samples per sine cycle (LUT depth), >= 2
(localparam IDXW = clog2(PASOS), index width)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  run enable; low freezes all counters and forces outputs low
modo  input  1  0 = sine LUT duty, 1 = fixed duty from duty_fijo on all channels
duty_fijo  input  R  duty used when modo=1 (high clocks per period)
pasos_por_muestra  input  16  carrier periods per LUT step; 0 treated as 1
fase  input  CANALES*IDXW  per-channel phase offset in LUT steps; channel c at bits [c*IDXW +: IDXW]
pwm_out  output  CANALES  registered PWM outputs
fin_periodo  output  1  one-cycle pulse after each carrier wrap
indice  output  IDXW  current base LUT index (before phase offset)

Behaviour:
- Reset: rst is sampled at a clock edge. Q=0, n=0, indice=0, all ciclo_act=0, pwm_out=0, fin_periodo=0. Reset mid-operation: all outputs are 0 in the cycle after the rst edge, and state restarts from zero.
- Carrier: Q (R bits) increments each clock when en=1 and wraps 2^R-1 -> 0. wrap = en & (Q == 2^R-1).
- LUT: LUT[k] = floor((2^R-1)*(1+sin(2*pi*k/PASOS))/2 + 0.5), built at elaboration. For R=6, PASOS=36: LUT[0]=32, LUT[9]=63, LUT[12]=59, LUT[24]=4, LUT[27]=0.
- Channel index: idx_c = indice + fase_c, minus PASOS if >= PASOS. A fase_c >= PASOS is out of contract and is treated as 0.
- Next duty: ciclo_sig_c = LUT[idx_c] if modo=0, else duty_fijo.
- At a wrap edge:
  - ciclo_act_c <= ciclo_sig_c, using indice before any increment.
  - If n == max(pasos_por_muestra,1)-1: n <= 0 and indice advances (PASOS-1 -> 0). Otherwise n <= n+1.
  - fin_periodo <= 1. It is 0 on every other edge.
- Changes to modo, duty_fijo, fase or pasos_por_muestra mid-period take effect only at the next wrap. No mid-period duty change is allowed.
- Output: pwm_out[c] <= en & (Q < ciclo_act_c). This is one clock of latency from Q.
  - With en steady, each channel is high for exactly ciclo_act_c consecutive clocks per 2^R-clock period.
  - Duty 0 gives constant low. Maximum duty 2^R-1 gives one low clock per period.
- First period after reset: all pwm_out low (ciclo_act=0) until the first wrap loads real duties.
- en=0: Q, n, indice and ciclo_act hold. pwm_out=0 and fin_periodo=0 from the next edge. On re-enable, counting resumes from the held Q with no period restart.
- en=1 and rst=1 on the same edge: rst wins.
- A sine cycle lasts PASOS * max(pasos_por_muestra,1) * 2^R clocks.

Test Plan:
1. Fixed duty: rst, then en=1, modo=1, duty_fijo=16 (R=6).
   -> pwm_out=0 for the first 64 clocks.
   -> Then every channel is high for 16 of every 64 clocks; fin_periodo pulses once per 64 clocks.
2. Sine, channel 0: modo=0, pasos_por_muestra=1, fase=0.
   -> Successive period duties are 32, LUT[1], ..., 63 at step 9, 0 at step 27.
   -> indice wraps 35 -> 0; the pattern repeats every 36*64 = 2304 clocks.
3. Phase offsets: CANALES=3, fase={24,12,0}.
   -> The first loaded duties are 32 / 59 / 4 on channels 0 / 1 / 2.
   -> Every channel follows the channel 0 sequence shifted by 12 and 24 steps.
4. Step rate: pasos_por_muestra=3, then 0.
   -> indice advances every 3rd fin_periodo; with 0 it advances every fin_periodo, identical to a setting of 1.
5. Enable gap: en=0 at Q=20 for 10 clocks, then en=1.
   -> pwm_out goes low on the next clock; Q stays 20 and no fin_periodo pulses.
   -> Counting resumes at 21; the duty pattern continues unchanged.
6. Mid-run reset: rst=1 for one edge while modo=0 and indice=20.
   -> The next cycle has pwm_out=0, indice=0 and fin_periodo=0.
   -> The first wrap after reset loads LUT[0+fase_c].
